// File: rtl/register_file_pkg.sv
// Shared widths, index/word types and the hardwired-zero index for the 16-bit register file.
package register_file_pkg;
   localparam int REG_WIDTH        = 16;
   localparam int REG_SELECT_WIDTH = 4;
   localparam int REG_COUNT        = 1 << REG_SELECT_WIDTH;

   typedef logic [REG_SELECT_WIDTH-1:0] reg_index_t;
   typedef logic [REG_WIDTH-1:0]        reg_word_t;

   localparam reg_index_t REG_ZERO = '0;
endpackage

// File: rtl/register_file_mux.sv
// Generalized 2**SELECT_WIDTH-to-1 multiplexer of WIDTH-bit words.
module register_file_mux #(
   parameter int WIDTH        = 16,
   parameter int SELECT_WIDTH = 4
) (
   input  logic [2**SELECT_WIDTH-1:0][WIDTH-1:0] i_data,
   input  logic [SELECT_WIDTH-1:0]               i_select,
   output logic [WIDTH-1:0]                      o_data
);
   assign o_data = i_data[i_select];
endmodule

// File: rtl/register_file.sv
// Register file with per-register pending bits for decode hazard stalls.
// Optional write-back bypass onto the read ports: define REGFILE_BYPASS_EN.
module register_file
   import register_file_pkg::*;
#(
   parameter int WIDTH        = REG_WIDTH,
   parameter int SELECT_WIDTH = REG_SELECT_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [SELECT_WIDTH-1:0] rd_index_a,
   input  logic [SELECT_WIDTH-1:0] rd_index_b,
   input  logic                    use_a,
   input  logic                    use_b,
   output logic [WIDTH-1:0]        rd_data_a,
   output logic [WIDTH-1:0]        rd_data_b,
   output logic                    busy_a,
   output logic                    busy_b,
   input  logic                    issue_en,
   input  logic [SELECT_WIDTH-1:0] issue_index,
   output logic                    stall,
   input  logic                    wr_en,
   input  logic [SELECT_WIDTH-1:0] wr_index,
   input  logic [WIDTH-1:0]        wr_data
);
   localparam int                      L_COUNT = 2**SELECT_WIDTH;
   localparam logic [SELECT_WIDTH-1:0] L_ZERO  = SELECT_WIDTH'(REG_ZERO);

   logic [L_COUNT-1:0][WIDTH-1:0] r_regs;
   logic [L_COUNT-1:0]            r_pending;

   logic [SELECT_WIDTH-1:0] w_rd_index [2];
   logic                    w_use      [2];
   logic [WIDTH-1:0]        w_mux_data [2];
   logic [WIDTH-1:0]        w_rd_data  [2];
   logic [1:0]              w_bypass;
   logic [1:0]              w_busy;
   logic [1:0]              w_hazard;
   logic                    w_waw;
   logic                    w_wr_hit;
   logic                    w_issue_set;

   assign w_rd_index[0] = rd_index_a;
   assign w_rd_index[1] = rd_index_b;
   assign w_use[0]      = use_a;
   assign w_use[1]      = use_b;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         register_file_mux #(
            .WIDTH       (WIDTH),
            .SELECT_WIDTH(SELECT_WIDTH)
         ) u_mux (
            .i_data  (r_regs),
            .i_select(w_rd_index[gi]),
            .o_data  (w_mux_data[gi])
         );

`ifdef REGFILE_BYPASS_EN
         assign w_bypass[gi] = wr_en && (wr_index == w_rd_index[gi]) && (w_rd_index[gi] != L_ZERO);
`else
         assign w_bypass[gi] = 1'b0;
`endif

         // Zero override is applied last so r0 reads 0 regardless of storage or bypass.
         assign w_rd_data[gi] = (w_rd_index[gi] == L_ZERO) ? '0 :
                                w_bypass[gi]               ? wr_data : w_mux_data[gi];
         assign w_busy[gi]    = r_pending[w_rd_index[gi]] & ~w_bypass[gi];
         assign w_hazard[gi]  = w_use[gi] & w_busy[gi];
      end
   endgenerate

   assign rd_data_a = w_rd_data[0];
   assign rd_data_b = w_rd_data[1];
   assign busy_a    = w_busy[0];
   assign busy_b    = w_busy[1];

   // WAW term is never bypassed: a same-edge write-back cannot free the slot for a new producer.
   assign w_waw       = issue_en & r_pending[issue_index];
   assign stall       = (|w_hazard) | w_waw;
   assign w_wr_hit    = wr_en && (wr_index != L_ZERO);
   assign w_issue_set = issue_en && !stall && (issue_index != L_ZERO);

   // Issue set is ordered after the write-back clear so a same-edge new producer wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_regs    <= '0;
         r_pending <= '0;
      end else begin
         if (w_wr_hit) begin
            r_regs[wr_index]    <= wr_data;
            r_pending[wr_index] <= 1'b0;
         end
         if (w_issue_set) begin
            r_pending[issue_index] <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_register_file.sv
// Scoreboarded random and directed bench for register_file; the driver pushes expected
// outputs from an array-based model, and a negedge monitor pops and compares them.
module tb_register_file;
   import register_file_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n;
   reg_index_t rd_index_a, rd_index_b, issue_index, wr_index;
   logic       use_a, use_b, issue_en, wr_en;
   reg_word_t  wr_data, rd_data_a, rd_data_b;
   logic       busy_a, busy_b, stall;

   always #5 clk = ~clk;

   register_file dut (
      .clk(clk), .reset_n(reset_n),
      .rd_index_a(rd_index_a), .rd_index_b(rd_index_b),
      .use_a(use_a), .use_b(use_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .busy_a(busy_a), .busy_b(busy_b),
      .issue_en(issue_en), .issue_index(issue_index), .stall(stall),
      .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data)
   );

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      int        id;
      reg_word_t da;
      reg_word_t db;
      logic      ba;
      logic      bb;
      logic      st;
   } exp_t;

   exp_t      q[$];
   reg_word_t m_regs [REG_COUNT];
   bit        m_pend [REG_COUNT];
   int        checks   = 0;
   int        failures = 0;
   int        txn_id   = 0;
   bit        done     = 1'b0;

   function automatic bit m_bypass(reg_index_t idx);
      return BYP && wr_en && (wr_index == idx) && (idx != 0);
   endfunction

   function automatic reg_word_t m_read(reg_index_t idx);
      if (idx == 0) return '0;
      if (m_bypass(idx)) return wr_data;
      return m_regs[idx];
   endfunction

   function automatic logic m_busy(reg_index_t idx);
      return m_pend[idx] && !m_bypass(idx);
   endfunction

   task automatic m_clear();
      for (int i = 0; i < REG_COUNT; i++) begin
         m_regs[i] = '0;
         m_pend[i] = 1'b0;
      end
   endtask

   // One clock of stimulus: drive just after the rising edge, predict, then advance the model.
   task automatic cycle(input logic rst, input reg_index_t ra, input reg_index_t rb,
                        input logic ua, input logic ub, input logic ie, input reg_index_t ii,
                        input logic we, input reg_index_t wi, input reg_word_t wd);
      exp_t e;
      @(posedge clk);
      #1;
      reset_n = rst; rd_index_a = ra; rd_index_b = rb; use_a = ua; use_b = ub;
      issue_en = ie; issue_index = ii; wr_en = we; wr_index = wi; wr_data = wd;
      if (!rst) m_clear();
      e.id = txn_id++;
      e.da = m_read(ra);
      e.db = m_read(rb);
      e.ba = m_busy(ra);
      e.bb = m_busy(rb);
      e.st = (ua && e.ba) || (ub && e.bb) || (ie && m_pend[ii]);
      q.push_back(e);
      if (rst) begin
         if (we && wi != 0) begin
            m_regs[wi] = wd;
            m_pend[wi] = 1'b0;
         end
         if (ie && !e.st && ii != 0) m_pend[ii] = 1'b1;
      end
   endtask

   task automatic rd(input reg_index_t ra, input reg_index_t rb, input logic ua, input logic ub);
      cycle(1'b1, ra, rb, ua, ub, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
   endtask

   task automatic chk(input string name, input int id, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s txn=%0d actual=%h required=%h", name, id, act, req);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("rd_data_a", e.id, rd_data_a, e.da);
            chk("rd_data_b", e.id, rd_data_b, e.db);
            chk("busy_a", e.id, {15'd0, busy_a}, {15'd0, e.ba});
            chk("busy_b", e.id, {15'd0, busy_b}, {15'd0, e.bb});
            chk("stall", e.id, {15'd0, stall}, {15'd0, e.st});
            $display("txn %0d rst_n=%0b a=%0d/%h b=%0d/%h busy=%0b%0b stall=%0b", e.id, reset_n,
                     rd_index_a, rd_data_a, rd_index_b, rd_data_b, busy_a, busy_b, stall);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      if (!done) begin
         $display("FAIL watchdog actual=timeout required=finish");
         $fatal(1, "watchdog expired");
      end
   end

   initial begin : driver
      reset_n = 1'b0; rd_index_a = '0; rd_index_b = '0; use_a = 0; use_b = 0;
      issue_en = 0; issue_index = '0; wr_en = 0; wr_index = '0; wr_data = '0;
      m_clear();
      cycle(1'b0, 4'd3, 4'd9, 1'b1, 1'b1, 1'b1, 4'd2, 1'b0, 4'd0, 16'h0);
      cycle(1'b0, 4'd6, 4'd1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
      for (int i = 0; i < REG_COUNT; i++) rd(reg_index_t'(i), reg_index_t'(REG_COUNT-1-i), 1'b1, 1'b1);

      cycle(1'b1, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 16'hBEEF);
      rd(4'd5, 4'd5, 1'b1, 1'b0);
      cycle(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd0, 16'h1234);
      rd(4'd0, 4'd5, 1'b1, 1'b1);

      // RAW on r3
      cycle(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 16'h0);
      rd(4'd3, 4'd0, 1'b1, 1'b0);
      rd(4'd3, 4'd0, 1'b1, 1'b0);
      cycle(1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd3, 16'h00AA);
      rd(4'd3, 4'd0, 1'b1, 1'b0);

      // WAW on r7
      cycle(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 4'd0, 16'h0);
      cycle(1'b1, 4'd7, 4'd0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 4'd0, 16'h0);
      cycle(1'b1, 4'd7, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd7, 16'h7777);
      cycle(1'b1, 4'd7, 4'd0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 4'd0, 16'h0);
      rd(4'd7, 4'd7, 1'b0, 1'b0);

      // Same-edge issue and write-back on r4, then unused pending port
      cycle(1'b1, 4'd4, 4'd0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b1, 4'd4, 16'h5555);
      rd(4'd4, 4'd4, 1'b0, 1'b0);
      rd(4'd4, 4'd7, 1'b0, 1'b1);

      // Mid-run asynchronous reset after writes
      cycle(1'b0, 4'd5, 4'd4, 1'b1, 1'b1, 1'b1, 4'd4, 1'b0, 4'd0, 16'h0);
      rd(4'd5, 4'd4, 1'b1, 1'b1);

      for (int n = 0; n < 400; n++) begin
         logic rst;
         rst = ($urandom_range(0, 99) != 0);
         cycle(rst, reg_index_t'($urandom_range(0, 15)), reg_index_t'($urandom_range(0, 15)),
               1'($urandom), 1'($urandom), 1'($urandom), reg_index_t'($urandom_range(0, 15)),
               rst && ($urandom_range(0, 9) < 4), reg_index_t'($urandom_range(0, 15)),
               reg_word_t'($urandom));
      end

      rd(4'd0, 4'd0, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      chk("queue_drained", txn_id, 16'(q.size()), 16'd0);
      done = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
